neg_abs_pipe: RTL and testbench
===============================

// Module: neg_abs_pipe
// PURPOSE
//   Parametrised, pipelined two's-complement sign unit.
//   Per sample: pass, negate, absolute value or negative-absolute, selected by in_mode.
//   Successor to the single-function registered negator, adding width/depth parameters,
//   a valid/ready handshake with backpressure, an overflow flag and a saturating overflow counter.
//   Sits between stream producers/consumers in the math datapath library.
// PARAMETERS
//   WIDTH   32  data width in bits, >= 2
//   STAGES  2   pipeline register stages, >= 1; compute in stage 0, stages 1..STAGES-1 delay only
//   CNT_W   16  width of overflow counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          synchronous reset, active low
//   in_valid   in   1          input sample valid
//   in_ready   out  1          unit accepts sample this cycle
//   in_mode    in   2          00 pass, 01 -a, 10 |a|, 11 -|a|
//   in_a       in   WIDTH      signed two's-complement operand
//   out_valid  out  1          output sample valid
//   out_ready  in   1          downstream accepts sample
//   out_z      out  WIDTH      signed result
//   out_ovf    out  1          result overflowed, qualified by out_valid
//   ovf_cnt    out  CNT_W      overflows delivered, saturating
//   ovf_clr    in   1          synchronous clear of ovf_cnt
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): all stage valid bits=0, out_z=0, out_ovf=0, ovf_cnt=0.
//     In-flight samples are discarded. in_ready=1 in the cycle after reset.
//   - Handshake: transfer in when in_valid&in_ready; transfer out when out_valid&out_ready.
//     in_valid/in_a/in_mode are not sampled unless in_ready=1.
//   - Per stage i: ready_i = !valid_i | ready_{i+1}; ready_STAGES = out_ready; in_ready = ready_0.
//     A stage loads when its ready is high; it holds data and valid when stalled.
//     Full throughput of 1 sample/cycle when out_ready=1.
//   - Latency: an accepted sample appears on out_z exactly STAGES cycles after acceptance,
//     absent stalls. Order is preserved. No sample is dropped or duplicated under any
//     out_ready pattern.
//   - Arithmetic, MIN = 1<<(WIDTH-1):
//       - mode 00: z = a, ovf = 0.
//       - mode 01: z = ~a+1 (mod 2^WIDTH), ovf = (a==MIN).
//       - mode 10: z = a<0 ? ~a+1 : a, ovf = (a==MIN).
//       - mode 11: z = a>0 ? ~a+1 : a, ovf = 0.
//     Wrapped result for MIN in modes 01/10 is MIN.
//   - out_z/out_ovf hold their values while out_valid & !out_ready. They are don't-care
//     when out_valid=0, but hold their last value in the RTL.
//   - ovf_cnt increments on each output transfer with out_ovf=1; it saturates at 2^CNT_W-1.
//     Clear and increment in the same cycle: clear wins, result 0.
// CONFIGURATION
//   NEG_ABS_SATURATE_EN defined:
//     - When ovf=1, out_z = MIN-1, i.e. 0x7FFF_FFFF at WIDTH=32.
//     - out_ovf and ovf_cnt behave as below.
//   Undefined:
//     - Wrapped result (MIN) is output.
//     - out_ovf and ovf_cnt unchanged.
// TESTING  (WIDTH=32, STAGES=2, CNT_W=16)
//   - Reset: rst_n=0 for 2 cycles mid-stream -> out_valid=0, ovf_cnt=0, out_z=0,
//     in_ready=1 next cycle.
//   - Streaming, out_ready=1: mode 01 on 5, 0, -1, 0x7FFFFFFF
//     -> out_z -5, 0, 1, 0x80000001 at 2 cycles each after input, 1/cycle.
//   - Overflow: mode 01 a=0x80000000 -> out_z=0x80000000 (0x7FFFFFFF with
//     NEG_ABS_SATURATE_EN), out_ovf=1, ovf_cnt=1. Mode 11 a=0x80000000 -> 0x80000000, ovf=0.
//   - Modes: a=-7 -> mode 00: -7, 10: 7, 11: -7. a=7 -> mode 11: -7.
//   - Backpressure: random out_ready (50%), 1000 random a/mode
//     -> output sequence equals reference model in order, no loss or duplication.
//     With out_ready=0, in_ready falls after 2 accepts.
//   - Counter: 65537 overflow samples -> ovf_cnt=0xFFFF. Then ovf_clr=1 coincident with an
//     overflow transfer -> ovf_cnt=0.

Source files
------------

// File: rtl/neg_abs_pipe.sv
// neg_abs_pipe -- pipelined two's-complement sign unit.
//
// Per accepted sample the unit passes, negates, takes the absolute value of,
// or takes the negative absolute value of in_a, selected by in_mode:
//   00 pass, 01 -a, 10 |a|, 11 -|a|
// The result is computed in stage 0. Stages 1..STAGES-1 only delay it. Each
// stage has its own valid bit and a valid/ready handshake, so backpressure
// from out_ready stalls the pipe without losing or duplicating samples.
//
// Optional feature (compile-time macro NEG_ABS_SATURATE_EN):
//   defined   -> an overflowing result is clamped to MIN-1 (largest positive)
//   undefined -> the wrapped result (MIN) is delivered
//   out_ovf and ovf_cnt behave identically in both builds.
//
// Parameters:
//   WIDTH   data width (>= 2)
//   STAGES  pipeline register stages (>= 1)
//   CNT_W   overflow counter width
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   input sample valid
//   in_ready   unit accepts a sample this cycle
//   in_mode    operation select
//   in_a       signed operand
//   out_valid  output sample valid
//   out_ready  downstream accepts the sample
//   out_z      signed result
//   out_ovf    result overflowed (qualified by out_valid)
//   ovf_cnt    saturating count of delivered overflow samples
//   ovf_clr    synchronous clear of ovf_cnt (wins over increment)
module neg_abs_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  localparam logic [WIDTH-1:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Per-stage state
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  dat [STAGES];
  logic              ovq [STAGES];

  // Stage 0 arithmetic
  logic [WIDTH-1:0] neg_a;
  logic             is_min;
  logic             is_neg;
  logic             is_pos;
  logic [WIDTH-1:0] c_z;
  logic             c_ovf;

  always_comb begin
    neg_a  = ~in_a + ONE_V;
    is_min = (in_a == MIN_V);
    is_neg = in_a[WIDTH-1];
    is_pos = !in_a[WIDTH-1] && (in_a != '0);
    c_z    = in_a;
    c_ovf  = 1'b0;
    case (in_mode)
      2'b00: begin
        c_z   = in_a;
        c_ovf = 1'b0;
      end
      2'b01: begin
        c_z   = neg_a;
        c_ovf = is_min;
      end
      2'b10: begin
        c_z   = is_neg ? neg_a : in_a;
        c_ovf = is_min;
      end
      default: begin
        c_z   = is_pos ? neg_a : in_a;
        c_ovf = 1'b0;
      end
    endcase
`ifdef NEG_ABS_SATURATE_EN
    if (c_ovf) begin
      c_z = ~MIN_V;
    end
`else
`endif
  end

  // ready_i = !valid_i | ready_{i+1}, unrolled so each stage's ready depends
  // only on valid bits and out_ready (no self-referencing vector).
  always_comb begin
    rdy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      rdy[i] = out_ready;
      for (int unsigned j = i; j < STAGES; j++) begin
        if (!vld[j]) begin
          rdy[i] = 1'b1;
        end
      end
    end
  end

  // Data only moves with a valid sample, so outputs keep their last value
  // through bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        dat[i] <= '0;
        ovq[i] <= 1'b0;
      end
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          dat[0] <= c_z;
          ovq[0] <= c_ovf;
        end
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            dat[i] <= dat[i-1];
            ovq[i] <= ovq[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + CNT_ONE;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign out_z     = dat[STAGES-1];
  assign out_ovf   = ovq[STAGES-1];

endmodule

// File: tb/tb_neg_abs_pipe.sv
// Testbench for neg_abs_pipe (WIDTH=32, STAGES=2, CNT_W=16).
// Expected results are queued when a sample is accepted and are popped when
// the unit delivers an output.
module tb_neg_abs_pipe;

  localparam int STAGES = 2;
  localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef NEG_ABS_SATURATE_EN
  localparam logic [31:0] OVZ = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVZ = 32'h8000_0000;
`endif

  typedef struct {
    logic [31:0] z;
    logic        ovf;
    int          stamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [31:0] in_a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        out_ovf;
  logic [15:0] ovf_cnt;
  logic        ovf_clr;

  neg_abs_pipe #(.WIDTH(32), .STAGES(STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_ovf(out_ovf),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  exp_t        pend;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          mcnt = 0;
  logic        chk_lat = 1'b0;
  logic        last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [1:0] m);
    exp_t   e;
    longint sa;
    sa = longint'($signed(a));
    e.stamp = 0;
    case (m)
      2'd0: begin e.z = a; e.ovf = 1'b0; end
      2'd1: begin e.z = 32'(-sa); e.ovf = (sa == -64'sd2147483648); end
      2'd2: begin e.z = (sa < 0) ? 32'(-sa) : a; e.ovf = (sa == -64'sd2147483648); end
      default: begin e.z = (sa > 0) ? 32'(-sa) : a; e.ovf = 1'b0; end
    endcase
`ifdef NEG_ABS_SATURATE_EN
    if (e.ovf) e.z = 32'h7FFF_FFFF;
`endif
    return e;
  endfunction

  // One clock: settle, score handshakes, advance past the edge.
  task automatic cycle();
    exp_t e;
    logic xfer_ovf;
    #1;
    last_acc = 1'b0;
    xfer_ovf = 1'b0;
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_z", 64'(out_z), 64'(e.z));
          chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
          if (chk_lat) chk("latency", 64'(cyc - e.stamp), 64'(STAGES));
          xfer_ovf = e.ovf;
        end
      end
      if (ovf_clr) mcnt = 0;
      else if (xfer_ovf && mcnt != 65535) mcnt++;
      if (in_valid && in_ready) begin
        pend.stamp = cyc;
        sb.push_back(pend);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [31:0] a, input logic [1:0] m,
                      input logic [31:0] z, input logic o);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_mode  = m;
    pend.z   = z;
    pend.ovf = o;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 1000);
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    cycle();
  endtask

  initial begin
    exp_t e;
    int   acc;
    int   guard;
    logic [31:0] ra;
    logic [1:0]  rm;

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'd0; in_a = '0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_ovf_cnt", 64'(ovf_cnt), 64'd0);

    // Reset mid-stream with a full, stalled pipe
    out_ready = 1'b0;
    send(32'd11, 2'd1, 32'hFFFF_FFF5, 1'b0);
    send(MINV, 2'd1, OVZ, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle(); cycle();
    sb.delete();
    mcnt = 0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk("rst_out_z", 64'(out_z), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming negate, latency STAGES, one per cycle
    chk_lat = 1'b1;
    send(32'd5,          2'd1, 32'hFFFF_FFFB, 1'b0);
    send(32'd0,          2'd1, 32'd0,         1'b0);
    send(32'hFFFF_FFFF,  2'd1, 32'd1,         1'b0);
    send(32'h7FFF_FFFF,  2'd1, 32'h8000_0001, 1'b0);
    drain();

    // Overflow
    send(MINV, 2'd1, OVZ,  1'b1);
    send(MINV, 2'd3, MINV, 1'b0);
    drain();
    chk("ovf_cnt_one", 64'(ovf_cnt), 64'd1);

    // Modes
    send(32'hFFFF_FFF9, 2'd0, 32'hFFFF_FFF9, 1'b0);
    send(32'hFFFF_FFF9, 2'd2, 32'd7,         1'b0);
    send(32'hFFFF_FFF9, 2'd3, 32'hFFFF_FFF9, 1'b0);
    send(32'd7,         2'd3, 32'hFFFF_FFF9, 1'b0);
    send(32'd7,         2'd2, 32'd7,         1'b0);
    send(MINV,          2'd2, OVZ,           1'b1);
    drain();
    chk("ovf_cnt_two", 64'(ovf_cnt), 64'd2);
    chk_lat = 1'b0;

    // in_ready falls after two accepts when out_ready=0
    out_ready = 1'b0;
    send(32'd1, 2'd0, 32'd1, 1'b0);
    send(32'd2, 2'd0, 32'd2, 1'b0);
    in_valid = 1'b1;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    cycle();
    chk("stall_hold_z", 64'(out_z), 64'd1);
    drain();

    // Random backpressure
    acc = 0;
    guard = 0;
    while (acc < 1000 && guard < 20000) begin
      out_ready = ($urandom % 2) == 0;
      in_valid  = ($urandom % 4) != 0;
      case ($urandom % 8)
        0: ra = MINV;
        1: ra = 32'd0;
        2: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      rm = 2'($urandom % 4);
      in_a = ra;
      in_mode = rm;
      e = model(ra, rm);
      pend.z = e.z;
      pend.ovf = e.ovf;
      cycle();
      if (last_acc) acc++;
      guard++;
    end
    chk("rand_accepts", 64'(acc), 64'd1000);
    drain();
    chk("rand_ovf_cnt", 64'(ovf_cnt), 64'(mcnt));

    // Counter saturation
    for (int i = 0; i < 65537; i++) send(MINV, 2'd1, OVZ, 1'b1);
    drain();
    chk("cnt_sat", 64'(ovf_cnt), 64'hFFFF);
    chk("cnt_sat_model", 64'(ovf_cnt), 64'(mcnt));

    // Clear coincident with an overflow transfer
    send(MINV, 2'd1, OVZ, 1'b1);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      cycle();
      guard++;
    end
    chk("clr_out_valid", 64'(out_valid), 64'd1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("clr_ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk("clr_model", 64'(mcnt), 64'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
